fdisc: RTL and testbench

Frequency discriminator that feeds the carrier frequency synchronizer. It takes strobed complex baseband samples (I/Q) and runs an iterative 15-step CORDIC in vectoring mode to get magnitude and phase. It then differentiates phase between successive samples and emits `mag`, `frq` and a one-cycle `fmv` strobe, with the scaling the synchronizer expects: magnitude full scale is 32768, and frequency full scale is 65536 per sample (16384 = +1/4 FS).

---
 rtl/fdisc.sv | 208 ++++++++++++++++++++
 tb/tb_fdisc.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdisc.sv
// -----------------------------------------------------------------------------
// fdisc -- frequency discriminator for the carrier frequency synchronizer.
//
// Each strobed I/Q sample is converted to magnitude and phase by an iterative
// CORDIC in vectoring mode, one micro-rotation per clock. The phase is then
// differentiated against the previous nonzero sample to give the per-sample
// phase step. Phase full scale is 65536 per turn; magnitude full scale 32768.
//
// Ports
//   clk   in   system clock, rising edge
//   rstn  in   asynchronous active-low reset
//   i     in   [15:0] signed in-phase sample
//   q     in   [15:0] signed quadrature sample
//   iqv   in   sample valid strobe (one cycle per sample)
//   mag   out  [15:0] unsigned magnitude, held between strobes
//   frq   out  [15:0] signed phase step per sample (mod 2^16), held
//   fmv   out  one-cycle strobe: mag/frq updated
//   ovf   out  one-cycle pulse: a sample arrived while busy and was dropped
//
// Timing: iqv sampled at edge E0, rotations at E1..E15, outputs registered at
// E16 (fmv high E16..E17). Next sample may be accepted at E17 at the earliest.
// -----------------------------------------------------------------------------
module fdisc #(
  parameter int ITER = 15,
  parameter int KSCL = 19899
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] i,
  input  logic [15:0] q,
  input  logic        iqv,
  output logic [15:0] mag,
  output logic [15:0] frq,
  output logic        fmv,
  output logic        ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_OUT} state_t;

  localparam logic [3:0]         K_LAST = 4'(ITER - 1);
  localparam logic signed [35:0] L_KSCL = 36'(KSCL);

  state_t             r_state;
  state_t             w_next;
  logic signed [17:0] r_x;
  logic signed [17:0] r_y;
  logic [15:0]        r_z;
  logic [15:0]        r_prev;
  logic [3:0]         r_k;
  logic               r_zflag;
  logic               r_first;
  logic [15:0]        r_mag;
  logic [15:0]        r_frq;
  logic               r_fmv;
  logic               r_ovf;

  logic signed [17:0] w_i_ext;
  logic signed [17:0] w_q_ext;
  logic signed [17:0] w_x_sh;
  logic signed [17:0] w_y_sh;
  logic [15:0]        w_atan;
  logic signed [35:0] w_x_ext;
  logic signed [19:0] w_mag_full;
  logic [15:0]        w_mag_sat;

  // Two guard bits so that negating i = -32768 cannot overflow.
  assign w_i_ext = {{2{i[15]}}, i};
  assign w_q_ext = {{2{q[15]}}, q};

  // Arithmetic, truncating shifts of the pre-update vector.
  assign w_x_sh = r_x >>> r_k;
  assign w_y_sh = r_y >>> r_k;

  // atan(2^-k) in units of 2^-16 turn.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    w_atan = 16'd0;
    case (r_k)
      4'd0:  w_atan = 16'd8192;
      4'd1:  w_atan = 16'd4836;
      4'd2:  w_atan = 16'd2555;
      4'd3:  w_atan = 16'd1297;
      4'd4:  w_atan = 16'd651;
      4'd5:  w_atan = 16'd326;
      4'd6:  w_atan = 16'd163;
      4'd7:  w_atan = 16'd81;
      4'd8:  w_atan = 16'd41;
      4'd9:  w_atan = 16'd20;
      4'd10: w_atan = 16'd10;
      4'd11: w_atan = 16'd5;
      4'd12: w_atan = 16'd3;
      4'd13: w_atan = 16'd1;
      4'd14: w_atan = 16'd1;
      default: w_atan = 16'd0;
    endcase
  end

  // Gain compensation: (x * KSCL) >> 15, saturated to the 16-bit range.
  assign w_x_ext    = {{18{r_x[17]}}, r_x};
  assign w_mag_full = 20'((w_x_ext * L_KSCL) >>> 15);

  always_comb begin
    w_mag_sat = w_mag_full[15:0];
    if (w_mag_full[19]) begin
      w_mag_sat = 16'd0;
    end else if (|w_mag_full[18:16]) begin
      w_mag_sat = 16'hFFFF;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: clocked state is always written with non-blocking assignments so
    // every register samples the values from before the edge.
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (iqv) w_next = S_ROT;
      S_ROT:   if (r_k == K_LAST) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_k     <= '0;
      r_prev  <= '0;
      r_zflag <= 1'b0;
      r_first <= 1'b0;
      r_mag   <= '0;
      r_frq   <= '0;
      r_fmv   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_fmv <= 1'b0;
      // A sample arriving while a conversion is in flight is simply dropped.
      r_ovf <= iqv && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (iqv) begin
            // Pre-rotate by 180 degrees into the right half-plane.
            if (!i[15]) begin
              r_x <= w_i_ext;
              r_y <= w_q_ext;
              r_z <= 16'h0000;
            end else begin
              r_x <= -w_i_ext;
              r_y <= -w_q_ext;
              r_z <= 16'h8000;
            end
            r_zflag <= (i == 16'd0) && (q == 16'd0);
            r_k     <= 4'd0;
          end
        end
        S_ROT: begin
          if (!r_y[17]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_atan;
          end
          r_k <= r_k + 4'd1;
        end
        S_OUT: begin
          r_fmv <= 1'b1;
          if (r_zflag) begin
            // Zero input has no phase; keep the last valid phase reference.
            r_mag <= 16'd0;
            r_frq <= 16'd0;
          end else begin
            r_mag <= w_mag_sat;
            if (!r_first) begin
              r_frq   <= 16'd0;
              r_first <= 1'b1;
            end else begin
              r_frq <= r_z - r_prev;
            end
            r_prev <= r_z;
          end
        end
        default: ;
      endcase
    end
  end

  assign mag = r_mag;
  assign frq = r_frq;
  assign fmv = r_fmv;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_fdisc.sv
// -----------------------------------------------------------------------------
// tb_fdisc -- self-checking bench for fdisc.
//
// The stimulus side issues samples and, using an ideal model (sqrt / atan2 on
// reals plus the accept/drop timing rule), pushes the expected response into
// a scoreboard queue. A monitor on the falling edge pops and compares each
// time the DUT strobes fmv or ovf, and flags any expected event that is late.
// -----------------------------------------------------------------------------
module tb_fdisc;

  localparam real PI = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] i;
  logic [15:0] q;
  logic        iqv;
  logic [15:0] mag;
  logic [15:0] frq;
  logic        fmv;
  logic        ovf;

  fdisc #(.ITER(15), .KSCL(19899)) dut (
    .clk  (clk),
    .rstn (rstn),
    .i    (i),
    .q    (q),
    .iqv  (iqv),
    .mag  (mag),
    .frq  (frq),
    .fmv  (fmv),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; edge numbers label sample and strobe times.
  int n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  int total = 0;
  int bad   = 0;
  int n_fmv = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, n_edge);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int  edge_n;
    int  mag;
    real frq;
    int  tm;
    int  tf;
  } exp_t;

  exp_t sb[$];
  int   ovf_q[$];

  bit  m_have;
  int  m_last;
  bit  m_first;
  real m_prev;
  int  tol_m;
  int  tol_f;

  function automatic real wrap(input real d);
    real r;
    r = d;
    while (r >= 32768.0) r = r - 65536.0;
    while (r < -32768.0) r = r + 65536.0;
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    ovf_q.delete();
    m_have  = 1'b0;
    m_last  = 0;
    m_first = 1'b0;
    m_prev  = 0.0;
  endtask

  // A sample is accepted only if at least 17 clocks have passed since the
  // last accepted one; otherwise an ovf pulse is due right after its edge.
  task automatic model_issue(input int si, input int sq, input int e0);
    exp_t e;
    real  ph;
    if (m_have && (e0 - m_last) < 17) begin
      ovf_q.push_back(e0);
      return;
    end
    m_have   = 1'b1;
    m_last   = e0;
    e.edge_n = e0 + 16;
    e.tm     = tol_m;
    e.tf     = tol_f;
    if (si == 0 && sq == 0) begin
      e.mag = 0;
      e.frq = 0.0;
      e.tm  = 0;
      e.tf  = 0;
    end else begin
      ph    = $atan2(real'(sq), real'(si)) * 65536.0 / (2.0 * PI);
      e.mag = $rtoi($sqrt(real'(si) * real'(si) + real'(sq) * real'(sq)) + 0.5);
      if (!m_first) begin
        e.frq   = 0.0;
        m_first = 1'b1;
      end else begin
        e.frq = wrap(ph - m_prev);
      end
      m_prev = ph;
    end
    sb.push_back(e);
  endtask

  // -------------------------------------------------------------- monitor
  always @(negedge clk) begin
    exp_t e;
    real  d;
    int   dm;
    int   eo;
    if (rstn === 1'b1) begin
      if (fmv === 1'b1) begin
        n_fmv++;
        check("fmv_expected", sb.size() > 0, 1, 0);
        if (sb.size() > 0) begin
          e  = sb.pop_front();
          check("fmv_edge", n_edge == e.edge_n, n_edge, e.edge_n);
          dm = int'(mag) - e.mag;
          check("mag", dm <= e.tm && dm >= -e.tm, int'(mag), e.mag);
          d  = wrap(real'($signed(frq)) - e.frq);
          check("frq", d <= real'(e.tf) && d >= -real'(e.tf), $signed(frq), $rtoi(e.frq));
        end
      end
      if (ovf === 1'b1) begin
        check("ovf_expected", ovf_q.size() > 0, 1, 0);
        if (ovf_q.size() > 0) begin
          eo = ovf_q.pop_front();
          check("ovf_edge", n_edge == eo, n_edge, eo);
        end
      end
      if (sb.size() > 0 && n_edge > sb[0].edge_n) begin
        check("fmv_missing", 1'b0, n_edge, sb[0].edge_n);
        void'(sb.pop_front());
      end
      if (ovf_q.size() > 0 && n_edge > ovf_q[0]) begin
        check("ovf_missing", 1'b0, n_edge, ovf_q[0]);
        void'(ovf_q.pop_front());
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  // Entered and left at posedge+1; iqv is sampled at the next rising edge,
  // and the following sample goes out 'period' clocks later.
  task automatic send(input int si, input int sq, input int period);
    int e0;
    i   = 16'(si);
    q   = 16'(sq);
    iqv = 1'b1;
    e0  = n_edge + 1;
    model_issue(si, sq, e0);
    @(posedge clk); #1;
    iqv = 1'b0;
    repeat (period - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mag"}, mag == 16'd0, mag, 0);
    check({tag, "_frq"}, frq == 16'd0, frq, 0);
    check({tag, "_fmv"}, fmv == 1'b0, fmv, 0);
    check({tag, "_ovf"}, ovf == 1'b0, ovf, 0);
  endtask

  initial begin
    int si;
    int sq;
    int per;
    int n_save;

    rstn  = 1'b0;
    i     = '0;
    q     = '0;
    iqv   = 1'b0;
    tol_m = 4;
    tol_f = 4;
    model_reset();
    idle(3);
    check_reset_outputs("reset");
    rstn = 1'b1;
    idle(2);

    // Constant on-axis input: frq is zero on every output.
    repeat (4) send(4096, 0, 32);

    // Quarter-rate rotating phasor.
    for (int r = 0; r < 2; r++) begin
      send(4096, 0, 20);
      send(0, 4096, 20);
      send(-4096, 0, 20);
      send(0, -4096, 20);
    end

    // Wrap across +/-180 degrees.
    tol_f = 8;
    repeat (2) begin
      send(-4096, 1, 17);
      send(-4096, -1, 17);
    end
    tol_f = 4;
    send(0, -4096, 17);
    send(0, 4096, 17);

    // Full scale, then zero between two nonzero samples.
    send(-32768, -32768, 17);
    send(4096, 0, 17);
    send(0, 0, 17);
    send(0, 4096, 17);

    // Overrun: iqv every 8 clocks.
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) send(8192, 0, 8);
      else            send(0, 8192, 8);
    end
    idle(20);

    // iqv exactly at E16 is dropped, at E17 accepted.
    send(4096, 0, 16);
    send(0, 4096, 1);
    send(0, 4096, 17);

    // Randomized samples with mostly legal and occasionally short periods.
    tol_m = 8;
    tol_f = 8;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        si = 0;
        sq = 0;
      end else begin
        do begin
          si = int'($urandom_range(0, 65535)) - 32768;
          sq = int'($urandom_range(0, 65535)) - 32768;
        end while (real'(si) * real'(si) + real'(sq) * real'(sq) < 67108864.0);
      end
      if ($urandom_range(0, 4) == 0) per = int'($urandom_range(4, 16));
      else                           per = int'($urandom_range(17, 22));
      send(si, sq, per);
    end
    idle(20);

    // Reset in the middle of a rotation aborts it.
    tol_m = 4;
    tol_f = 4;
    send(4096, 0, 20);
    send(0, 4096, 5);
    rstn = 1'b0;
    model_reset();
    n_save = n_fmv;
    #1;
    check_reset_outputs("midrot_reset");
    idle(3);
    rstn = 1'b1;
    idle(30);
    check("no_fmv_after_abort", n_fmv == n_save, n_fmv, n_save);

    // After reset the first output again reports frq = 0.
    send(0, 4096, 20);
    send(-4096, 0, 20);
    idle(20);

    check("scoreboard_drained", sb.size() == 0, sb.size(), 0);
    check("ovf_queue_drained", ovf_q.size() == 0, ovf_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got %0d, expected 0", n_edge);
    $fatal(1, "time limit");
  end

endmodule
